// File: rtl/blink_seq_if.sv
// Configuration handshake and blink outputs for the blink sequencer.
// Master drives cfg_valid/mode/period/count; slave returns cfg_ready, tick, led, done.
// cfg_ready is the only combinational return signal; the rest are registered.
interface blink_seq_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [DIV_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_count;
  logic             tick;
  logic             led;
  logic             done;

  modport master (
    output cfg_valid, cfg_mode, cfg_period, cfg_count,
    input  cfg_ready, tick, led, done
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_period, cfg_count,
    output cfg_ready, tick, led, done
  );
endinterface

// File: rtl/blink_seq.sv
// Blink sequencer: divides clk by P+1 into one-cycle tick pulses and a mirrored led level.
// Latency: first tick registered P+1 edges after config acceptance; done with the last burst tick.
// Backpressure: cfg_ready is low only while a counted burst runs; cfg_valid is ignored then.
module blink_seq #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 4
) (
  input logic       clk,
  input logic       reset,
  blink_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STEADY = 2'd1;
  localparam logic [1:0] S_BLINK  = 2'd2;
  localparam logic [1:0] S_BURST  = 2'd3;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  logic [1:0]       state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] period;
  logic [CNT_W:0]   remain;
  logic             tick;
  logic             led;
  logic             done;

  logic             accept;
  logic             running;
  logic             expire;
  logic             last_tick;
  logic             burst_zero;

  // Handshake and prescaler decode; a new config always beats a coinciding expiry.
  always_comb begin
    accept     = 1'b0;
    running    = 1'b0;
    expire     = 1'b0;
    last_tick  = 1'b0;
    burst_zero = 1'b0;
    accept     = bus.cfg_valid && (state != S_BURST);
    running    = (state == S_BLINK) || (state == S_BURST);
    expire     = running && (div == period) && !accept;
    last_tick  = expire && (state == S_BURST) && (remain == (CNT_W+1)'(1));
    burst_zero = (bus.cfg_mode == M_BURST) && (bus.cfg_count == '0);
  end

  // Mode state and remaining-toggle counter for counted bursts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      remain <= '0;
    end else if (accept) begin
      case (bus.cfg_mode)
        M_OFF:   state <= S_IDLE;
        M_ON:    state <= S_STEADY;
        M_BLINK: state <= S_BLINK;
        M_BURST: state <= burst_zero ? S_IDLE : S_BURST;
        default: state <= S_IDLE;
      endcase
      remain <= (bus.cfg_mode == M_BURST) ? {bus.cfg_count, 1'b0} : '0;
    end else if (expire && (state == S_BURST)) begin
      remain <= remain - (CNT_W+1)'(1);
      if (last_tick) begin
        state <= S_IDLE;
      end
    end
  end

  // Prescaler: counts 0..P while blinking, parked at 0 otherwise; P latched on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div    <= '0;
      period <= '0;
    end else if (accept) begin
      div    <= '0;
      period <= bus.cfg_period;
    end else if (!running || expire) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Registered outputs: tick pulse, led level, burst completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= 1'b0;
      led  <= 1'b0;
      done <= 1'b0;
    end else begin
      tick <= expire;
      done <= last_tick || (accept && burst_zero);
      if (accept) begin
        led <= (bus.cfg_mode == M_ON);
      end else if (expire) begin
        led <= ~led;
      end
    end
  end

  assign bus.cfg_ready = (state != S_BURST);
  assign bus.tick      = tick;
  assign bus.led       = led;
  assign bus.done      = done;

endmodule

// File: tb/tb_blink_seq.sv
// Directed bench for blink_seq: reset, blink, bursts, P=0, config-vs-tick collision, mid-burst reset.
module tb_blink_seq;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  blink_seq_if #(.DIV_W(16), .CNT_W(4)) bus();

  blink_seq #(.DIV_W(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns so outputs are stable for sampling/driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a config so it is accepted on the next edge; returns just after that edge.
  task automatic send(input logic [1:0] mode, input logic [15:0] p, input logic [3:0] n);
    bus.cfg_valid  = 1'b1;
    bus.cfg_mode   = mode;
    bus.cfg_period = p;
    bus.cfg_count  = n;
    cyc();
    bus.cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    total++; if (bus.led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", bus.led); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.cfg_ready); end
  endtask

  task automatic test_blink();
    logic et, el;
    send(2'd2, 16'd3, 4'd0);
    for (int e = 1; e <= 12; e++) begin
      cyc();
      et = (e % 4 == 0);
      el = ((e / 4) % 2 == 1);
      total++; if (bus.tick !== et) begin bad++; $display("FAIL blink_tick e=%0d got=%b exp=%b", e, bus.tick, et); end
      total++; if (bus.led !== el) begin bad++; $display("FAIL blink_led e=%0d got=%b exp=%b", e, bus.led, el); end
      total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL blink_ready e=%0d got=%b exp=1", e, bus.cfg_ready); end
    end
    // Asynchronous reset between edges: led (currently 1) and tick (currently 1) must clear at once.
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.led !== 1'b0) begin bad++; $display("FAIL async_reset_led got=%b exp=0", bus.led); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL async_reset_tick got=%b exp=0", bus.tick); end
    reset = 1'b1;
    cyc();
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL post_reset_idle_tick got=%b exp=0", bus.tick); end
  endtask

  task automatic test_burst();
    logic et, el, ed, er;
    send(2'd3, 16'd1, 4'd2);
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL burst_ready_start got=%b exp=0", bus.cfg_ready); end
    for (int e = 1; e <= 10; e++) begin
      // Mid-burst OFF request must be ignored.
      if (e == 3) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = 2'd0;
      end
      cyc();
      bus.cfg_valid = 1'b0;
      et = (e % 2 == 0) && (e <= 8);
      el = (e <= 8) && ((e / 2) % 2 == 1);
      ed = (e == 8);
      er = (e >= 8);
      total++; if (bus.tick !== et) begin bad++; $display("FAIL burst_tick e=%0d got=%b exp=%b", e, bus.tick, et); end
      total++; if (bus.led !== el) begin bad++; $display("FAIL burst_led e=%0d got=%b exp=%b", e, bus.led, el); end
      total++; if (bus.done !== ed) begin bad++; $display("FAIL burst_done e=%0d got=%b exp=%b", e, bus.done, ed); end
      total++; if (bus.cfg_ready !== er) begin bad++; $display("FAIL burst_ready e=%0d got=%b exp=%b", e, bus.cfg_ready, er); end
    end
  endtask

  task automatic test_burst_zero();
    send(2'd3, 16'd2, 4'd0);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL bz_done got=%b exp=1", bus.done); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL bz_tick got=%b exp=0", bus.tick); end
    total++; if (bus.led !== 1'b0) begin bad++; $display("FAIL bz_led got=%b exp=0", bus.led); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL bz_ready got=%b exp=1", bus.cfg_ready); end
    for (int e = 1; e <= 4; e++) begin
      cyc();
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL bz_done_after e=%0d got=%b exp=0", e, bus.done); end
      total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL bz_tick_after e=%0d got=%b exp=0", e, bus.tick); end
    end
  endtask

  task automatic test_p0_then_on();
    logic el;
    send(2'd2, 16'd0, 4'd0);
    for (int e = 1; e <= 4; e++) begin
      cyc();
      el = (e % 2 == 1);
      total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL p0_tick e=%0d got=%b exp=1", e, bus.tick); end
      total++; if (bus.led !== el) begin bad++; $display("FAIL p0_led e=%0d got=%b exp=%b", e, bus.led, el); end
    end
    // ON lands on an edge where a tick would fire: config wins.
    send(2'd1, 16'd0, 4'd0);
    for (int e = 0; e <= 3; e++) begin
      if (e > 0) cyc();
      total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL on_tick e=%0d got=%b exp=0", e, bus.tick); end
      total++; if (bus.led !== 1'b1) begin bad++; $display("FAIL on_led e=%0d got=%b exp=1", e, bus.led); end
    end
  endtask

  task automatic test_burst_reset();
    send(2'd3, 16'd2, 4'd3);
    repeat (9) cyc();
    total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL br_tick3 got=%b exp=1", bus.tick); end
    total++; if (bus.led !== 1'b1) begin bad++; $display("FAIL br_led3 got=%b exp=1", bus.led); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.led !== 1'b0) begin bad++; $display("FAIL br_reset_led got=%b exp=0", bus.led); end
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL br_reset_tick got=%b exp=0", bus.tick); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL br_reset_ready got=%b exp=1", bus.cfg_ready); end
    repeat (2) cyc();
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL br_no_done e=%0d got=%b exp=0", e, bus.done); end
    end
    send(2'd2, 16'd1, 4'd0);
    cyc();
    total++; if (bus.tick !== 1'b0) begin bad++; $display("FAIL br_blink_k1 got=%b exp=0", bus.tick); end
    cyc();
    total++; if (bus.tick !== 1'b1) begin bad++; $display("FAIL br_blink_k2 got=%b exp=1", bus.tick); end
    total++; if (bus.led !== 1'b1) begin bad++; $display("FAIL br_blink_led got=%b exp=1", bus.led); end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_mode   = 2'd0;
    bus.cfg_period = 16'd0;
    bus.cfg_count  = 4'd0;
    #1;
    test_reset();
    test_blink();
    test_burst();
    test_burst_zero();
    test_p0_then_on();
    test_burst_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/blink_seq.md
# blink_seq

Programmable blink sequencer that sits directly upstream of the LED toggle stage. It divides the system clock by a configurable period and emits one-cycle `tick` pulses, which the downstream toggle stage consumes as its toggle input. It also drives a mirrored `led` level for boards without that stage. Software-side logic loads a mode (off, steady on, continuous blink, counted burst) through a valid/ready handshake.

## Interface
- `DIV_W`, default 16: width of the period field and of the prescaler counter.
- `CNT_W`, default 4: width of the burst-count field.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Low forces reset immediately, independent of `clk`.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  configuration accepted this cycle when `cfg_valid & cfg_ready`.
- `cfg_mode`  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- `cfg_period`  in  DIV_W  P; tick interval is P+1 clock cycles.
- `cfg_count`  in  CNT_W  N; BURST length in full blinks (2N ticks).
- `tick`  out  1  one-cycle toggle pulse to the downstream toggle stage.
- `led`  out  1  LED level (toggles on every tick).
- `done`  out  1  one-cycle pulse when a BURST completes.

## Operation
- States: IDLE, STEADY, BLINK, BURST.
- `cfg_ready` is combinational and equals (state != BURST). New configurations are accepted in IDLE, STEADY and BLINK. While a burst is running, `cfg_valid` is ignored.
- On acceptance, P and N are latched, the prescaler `div` is cleared to 0, and `tick` is cleared to 0. The state moves by mode:
  - OFF: IDLE, `led`=0.
  - ON: STEADY, `led`=1, no ticks.
  - BLINK: BLINK, `led`=0.
  - BURST with N>0: BURST, `led`=0, remaining-toggle counter = 2N (width CNT_W+1).
  - BURST with N=0: IDLE, `led`=0, `done`=1 in the following cycle.
- Prescaler, active in BLINK and BURST only:
  - When `div`==P: `div`<=0, `tick`<=1, `led`<=~`led`.
  - Otherwise: `div`<=`div`+1, `tick`<=0.
  - P=0 gives a tick every cycle. The comparison is unsigned with no overflow, because `div` never exceeds P.
- BURST: each tick decrements the remaining-toggle counter. On the edge that issues the final (2N-th) tick, the state goes to IDLE and `done`<=1. `led` ends at 0.
- In IDLE and STEADY, `div` holds at 0 and `tick` stays 0.
- Simultaneous acceptance and prescaler expiry: the configuration wins. No tick is issued, and `div` restarts from 0.

## Timing
- Reset (`reset`=0):
  - Outputs: `tick`=0, `led`=0, `done`=0; `cfg_ready`=1, since state is IDLE.
  - Internal: `div`=0, counter=0, latched P and N = 0.
- Reset asserted mid-operation (including mid-burst) takes effect immediately. No `done` is issued for the aborted burst.
- Acceptance at edge k:
  - The first tick is registered at edge k+P+1 and is high for exactly one cycle.
  - Subsequent ticks are registered every P+1 edges.
  - `led` changes on the same edge as `tick` rises.
- BURST length: the last tick is at edge k+2N(P+1). `done` is high during the same cycle as that last tick. `cfg_ready` rises in that cycle, so a new configuration can be accepted at the next edge.
- BURST with N=0 accepted at edge k: `done` is high in the cycle after edge k, with no tick.
- `done` and `tick` are registered outputs. `cfg_ready` is the only combinational output.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release → `tick`=0, `led`=0, `done`=0, `cfg_ready`=1. Pulse `reset` low between edges → outputs clear with no clock edge.
- BLINK, P=3, accepted at edge k → `tick` high after edges k+4, k+8, k+12. `led` reads 1, 0, 1 after those edges. `cfg_ready` stays 1.
- BURST, N=2, P=1, accepted at edge k → ticks at k+2, k+4, k+6, k+8. `led` reads 1, 0, 1, 0. `done`=1 only in the cycle after edge k+8. `cfg_ready`=0 from k+1 to k+8. A `cfg_valid` pulse in mid-burst has no effect.
- BURST, N=0 → `done`=1 for one cycle after acceptance, `tick` never asserted, `led`=0.
- BLINK, P=0 → `tick` high every cycle. Then assert ON on an edge where a tick would fire → no tick, `led`=1, `tick` stays 0 thereafter.
- BURST, N=3, P=2: drive `reset`=0 after the 3rd tick → immediate IDLE, `led`=0, no `done`. After release, BLINK is accepted normally.
